sync_updown_counter: RTL and testbench
======================================

Name: sync_updown_counter

Overview:
- Parametrised, fully synchronous up/down counter; successor to the ripple-clocked up/down counter.
- All state sits on one clock domain, so it has no ripple glitches.
- Adds configurable width and modulus, and a wrap or saturate mode.
- Adds synchronous clear, parallel load, count enable, a terminal-count flag, and registered wrap and load-error pulses.
- Used as a general event/timer counter in datapath and control blocks.

Parameters:
- WIDTH, 4, counter width in bits (2..32).
- MODULO, 16, count range is 0..MODULO-1. Legal range is 2..2**WIDTH.
- SAT_MODE, 0, 0 = wrap at the range ends, 1 = saturate at the range ends.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset.
- clr  in  1  synchronous clear, highest priority.
- load  in  1  synchronous parallel load.
- load_val  in  WIDTH  value to load.
- en  in  1  count enable.
- up_down  in  1  direction: 1 = up, 0 = down.
- q  out  WIDTH  current count, registered.
- tc  out  1  terminal count, combinational:
  - 1 when q == MODULO-1 and up_down = 1;
  - 1 when q == 0 and up_down = 0.
- wrap  out  1  registered one-cycle pulse, set on the cycle after q wrapped (SAT_MODE = 0 only).
- sat  out  1  registered level, 1 while the counter is held at a range end by saturation (SAT_MODE = 1 only).
- load_err  out  1  registered one-cycle pulse, set on the cycle after a load with load_val >= MODULO.

Behaviour:
- Reset: rst = 0 forces q = 0, wrap = 0, sat = 0 and load_err = 0 immediately, with no clock needed. Deassertion takes effect on the next rising clk edge.
- Priority on each rising edge: clr, then load, then en, then hold.
- clr = 1:
  - q <= 0; wrap <= 0; sat <= 0; load_err <= 0.
- load = 1 (clr = 0):
  - If load_val < MODULO: q <= load_val, load_err <= 0.
  - Otherwise: q <= MODULO-1, load_err <= 1.
  - wrap <= 0. sat <= 1 only if SAT_MODE = 1 and the loaded value is a range end in the current direction.
- en = 1 (clr = 0, load = 0), up_down = 1:
  - If q < MODULO-1: q <= q+1.
  - At q == MODULO-1 with SAT_MODE = 0: q <= 0, wrap <= 1.
  - At q == MODULO-1 with SAT_MODE = 1: q holds, sat <= 1.
- en = 1 (clr = 0, load = 0), up_down = 0:
  - If q > 0: q <= q-1.
  - At q == 0 with SAT_MODE = 0: q <= MODULO-1, wrap <= 1.
  - At q == 0 with SAT_MODE = 1: q holds, sat <= 1.
- en = 0: q holds. wrap and load_err go to 0. sat keeps its value.
- sat clears on the first enabled count that moves q off the end, i.e. after a direction reversal.
- Latency:
  - q updates 1 cycle after the qualifying edge.
  - wrap, sat and load_err are aligned with the q update that caused them.
  - tc reflects the current q and up_down with zero latency.
- Arithmetic:
  - Comparisons are unsigned and WIDTH bits wide.
  - The next-value computation uses WIDTH+1 bits internally, so it cannot overflow.
  - When MODULO == 2**WIDTH, wrap behaviour matches natural binary rollover.
- Direction change mid-count takes effect on the same edge; it has no pipeline.
- A reset asserted mid-operation aborts any pending load or count; there is no partial update.
- Parameter guard: an elaboration-time check fails the build if MODULO < 2 or MODULO > 2**WIDTH.

Decomposition:
- Shared package counter_pkg holds:
  - SAT_MODE encodings CNT_WRAP = 0 and CNT_SAT = 1;
  - a function computing the required width from MODULO;
  - the priority-order constants for clr/load/en.
- One sub-module, counter_next_val:
  - combinational next-value and end-detect logic, parameterised by WIDTH, MODULO and SAT_MODE;
  - outputs next_q, at_end and wrap_evt;
  - the top level registers these outputs.

Test Plan:
- Reset and clear: WIDTH = 4, MODULO = 10. Count to q = 7, then pulse rst low mid-cycle → q = 0 immediately, with no clock. Release and count to 5, then assert clr → q = 0 on the next edge, wrap = 0.
- Up wrap: SAT_MODE = 0, MODULO = 10, count up from 0 → q runs 0..9 and 9 → 0. tc = 1 at q = 9. wrap = 1 for exactly one cycle with q = 0.
- Down wrap: SAT_MODE = 0, MODULO = 10, count down from 2 → q runs 2, 1, 0, 9. tc = 1 at q = 0. wrap pulses with q = 9.
- Saturate and reverse: SAT_MODE = 1, MODULO = 10, count up from 8 → q runs 8, 9, 9, 9 with sat = 1. Then set up_down = 0 → q = 8 and sat = 0.
- Load and priority:
  - load_val = 6 → q = 6, load_err = 0.
  - load_val = 12 with MODULO = 10 → q = 9, load_err pulses once.
  - clr = 1 and load = 1 together → q = 0.
  - load = 1 with en = 1 → q = load_val; no count occurs.
- Full range: WIDTH = 8, MODULO = 256, en held high → free-runs 255 → 0 with a wrap pulse. With en = 0 for 3 cycles, q holds and wrap = 0.

Source files
------------

// File: rtl/counter_pkg.sv
// Shared definitions for the synchronous up/down counter family:
// saturation-mode encodings, control priority order and a width helper.
package counter_pkg;

  // Range-end behaviour selected by the SAT_MODE parameter.
  localparam int CNT_WRAP = 0;
  localparam int CNT_SAT  = 1;

  // Priority rank of the synchronous controls; a lower rank wins.
  localparam int PRIO_CLR  = 0;
  localparam int PRIO_LOAD = 1;
  localparam int PRIO_EN   = 2;
  localparam int PRIO_HOLD = 3;

  // Operation selected on a clock edge, encoded by its priority rank.
  typedef enum logic [1:0] {
    OP_CLR   = 2'(PRIO_CLR),
    OP_LOAD  = 2'(PRIO_LOAD),
    OP_COUNT = 2'(PRIO_EN),
    OP_HOLD  = 2'(PRIO_HOLD)
  } cnt_op_e;

  // Number of bits needed to represent every count 0..modulo-1.
  function automatic int req_width(input longint unsigned modulo);
    int              w;
    longint unsigned v;
    w = 1;
    v = modulo - 64'd1;
    while (v > 64'd1) begin
      v = v >> 1;
      w = w + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/counter_next_val.sv
// Combinational next-count and range-end detection for one step of the
// counter in the current direction. Arithmetic is done one bit wider than
// the count so the carry/borrow out directly marks the range ends.
module counter_next_val
  import counter_pkg::*;
#(
  parameter int              WIDTH    = 4,
  parameter longint unsigned MODULO   = 16,
  parameter int              SAT_MODE = CNT_WRAP
) (
  input  logic [WIDTH-1:0] q,
  input  logic             up_down,
  output logic [WIDTH-1:0] next_q,
  output logic             at_end,
  output logic             wrap_evt
);

  localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULO);
  localparam logic [WIDTH-1:0] MAX_Q   = WIDTH'(MODULO - 64'd1);

  logic [WIDTH:0] inc_s;
  logic [WIDTH:0] dec_s;
  logic           end_up_s;
  logic           end_dn_s;

  // Step both ways in WIDTH+1 bits and flag the range end of each direction.
  always_comb begin
    inc_s    = {1'b0, q} + {{WIDTH{1'b0}}, 1'b1};
    dec_s    = {1'b0, q} - {{WIDTH{1'b0}}, 1'b1};
    end_up_s = (inc_s == MOD_EXT);
    end_dn_s = dec_s[WIDTH];
  end

  // Choose the successor: step, wrap to the opposite end, or hold when saturating.
  always_comb begin
    next_q   = q;
    wrap_evt = 1'b0;
    at_end   = up_down ? end_up_s : end_dn_s;
    if (at_end) begin
      if (SAT_MODE == CNT_SAT) begin
        next_q   = q;
        wrap_evt = 1'b0;
      end else begin
        next_q   = up_down ? {WIDTH{1'b0}} : MAX_Q;
        wrap_evt = 1'b1;
      end
    end else begin
      next_q   = up_down ? inc_s[WIDTH-1:0] : dec_s[WIDTH-1:0];
      wrap_evt = 1'b0;
    end
  end

endmodule

// File: rtl/sync_updown_counter.sv
// Parametrised fully synchronous up/down counter with clear, load, enable,
// wrap or saturate at the range ends, and registered status pulses.
module sync_updown_counter
  import counter_pkg::*;
#(
  parameter int              WIDTH    = 4,
  parameter longint unsigned MODULO   = 16,
  parameter int              SAT_MODE = CNT_WRAP
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  input  logic             up_down,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             wrap,
  output logic             sat,
  output logic             load_err
);

  localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(MODULO - 64'd1);

  // Reject parameter sets whose modulus cannot be held in WIDTH bits.
  if ((WIDTH < 2) || (WIDTH > 32) || (MODULO < 64'd2) ||
      (MODULO > (64'd1 << WIDTH)) || (req_width(MODULO) > WIDTH)) begin : g_param_guard
    $fatal(1, "sync_updown_counter: illegal WIDTH/MODULO combination");
  end

  logic [WIDTH-1:0] q_r;
  logic             wrap_r;
  logic             sat_r;
  logic             load_err_r;

  logic [WIDTH-1:0] q_nxt_s;
  logic             wrap_nxt_s;
  logic             sat_nxt_s;
  logic             load_err_nxt_s;

  logic [WIDTH-1:0] step_q_s;
  logic             at_end_s;
  logic             wrap_evt_s;
  logic [WIDTH-1:0] load_q_s;
  logic             load_bad_s;
  cnt_op_e          op_s;

  counter_next_val #(
    .WIDTH    (WIDTH),
    .MODULO   (MODULO),
    .SAT_MODE (SAT_MODE)
  ) u_next_val (
    .q        (q_r),
    .up_down  (up_down),
    .next_q   (step_q_s),
    .at_end   (at_end_s),
    .wrap_evt (wrap_evt_s)
  );

  // Resolve the control inputs into a single operation by priority.
  always_comb begin
    op_s = OP_HOLD;
    if (clr) begin
      op_s = OP_CLR;
    end else if (load) begin
      op_s = OP_LOAD;
    end else if (en) begin
      op_s = OP_COUNT;
    end else begin
      op_s = OP_HOLD;
    end
  end

  // Clamp out-of-range load values to the top of the range and flag them.
  always_comb begin
    load_bad_s = 1'b0;
    load_q_s   = load_val;
    if (load_val > MAX_Q) begin
      load_bad_s = 1'b1;
      load_q_s   = MAX_Q;
    end else begin
      load_bad_s = 1'b0;
      load_q_s   = load_val;
    end
  end

  // Next register values for the selected operation; pulses default low.
  always_comb begin
    q_nxt_s        = q_r;
    wrap_nxt_s     = 1'b0;
    sat_nxt_s      = sat_r;
    load_err_nxt_s = 1'b0;
    case (op_s)
      OP_CLR: begin
        q_nxt_s   = {WIDTH{1'b0}};
        sat_nxt_s = 1'b0;
      end
      OP_LOAD: begin
        q_nxt_s        = load_q_s;
        load_err_nxt_s = load_bad_s;
        sat_nxt_s      = (SAT_MODE == CNT_SAT) &&
                         (up_down ? (load_q_s == MAX_Q) : (load_q_s == {WIDTH{1'b0}}));
      end
      OP_COUNT: begin
        q_nxt_s    = step_q_s;
        wrap_nxt_s = wrap_evt_s;
        sat_nxt_s  = (SAT_MODE == CNT_SAT) && at_end_s;
      end
      OP_HOLD: begin
        q_nxt_s   = q_r;
        sat_nxt_s = sat_r;
      end
      default: begin
        q_nxt_s   = q_r;
        sat_nxt_s = sat_r;
      end
    endcase
  end

  // Count and status registers; reset clears everything without a clock.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q_r        <= {WIDTH{1'b0}};
      wrap_r     <= 1'b0;
      sat_r      <= 1'b0;
      load_err_r <= 1'b0;
    end else begin
      q_r        <= q_nxt_s;
      wrap_r     <= wrap_nxt_s;
      sat_r      <= sat_nxt_s;
      load_err_r <= load_err_nxt_s;
    end
  end

  assign q        = q_r;
  assign wrap     = wrap_r;
  assign sat      = sat_r;
  assign load_err = load_err_r;
  assign tc       = at_end_s;

endmodule

// File: tb/tb_sync_updown_counter.sv
// Self-checking bench: three counter configurations share one set of
// controls and are compared every cycle against arithmetic reference models.
module tb_sync_updown_counter;

  logic       clk = 1'b0;
  logic       rst;
  logic       clr;
  logic       load;
  logic       en;
  logic       up_down;
  logic [3:0] lv4;
  logic [7:0] lv8;

  logic [3:0] q_w, q_s;
  logic [7:0] q_f;
  logic tc_w, wrap_w, sat_w, lerr_w;
  logic tc_s, wrap_s, sat_s, lerr_s;
  logic tc_f, wrap_f, sat_f, lerr_f;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    int q;
    bit wrap;
    bit sat;
    bit lerr;
  } mdl_t;

  mdl_t m_w, m_s, m_f;

  sync_updown_counter #(.WIDTH(4), .MODULO(10), .SAT_MODE(0)) u_wrap (
    .clk(clk), .rst(rst), .clr(clr), .load(load), .load_val(lv4), .en(en),
    .up_down(up_down), .q(q_w), .tc(tc_w), .wrap(wrap_w), .sat(sat_w), .load_err(lerr_w));

  sync_updown_counter #(.WIDTH(4), .MODULO(10), .SAT_MODE(1)) u_sat (
    .clk(clk), .rst(rst), .clr(clr), .load(load), .load_val(lv4), .en(en),
    .up_down(up_down), .q(q_s), .tc(tc_s), .wrap(wrap_s), .sat(sat_s), .load_err(lerr_s));

  sync_updown_counter #(.WIDTH(8), .MODULO(256), .SAT_MODE(0)) u_full (
    .clk(clk), .rst(rst), .clr(clr), .load(load), .load_val(lv8), .en(en),
    .up_down(up_down), .q(q_f), .tc(tc_f), .wrap(wrap_f), .sat(sat_f), .load_err(lerr_f));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, obs, exp);
    end
  endtask

  // Reference behaviour for one rising edge, written from the counting rules.
  function automatic mdl_t step(input mdl_t m, input int modulo, input bit satm, input int lv);
    mdl_t n;
    n = m;
    n.wrap = 1'b0;
    n.lerr = 1'b0;
    if (clr) begin
      n.q = 0;
      n.sat = 1'b0;
    end else if (load) begin
      if (lv < modulo) n.q = lv;
      else begin
        n.q = modulo - 1;
        n.lerr = 1'b1;
      end
      n.sat = satm && ((up_down && n.q == modulo - 1) || (!up_down && n.q == 0));
    end else if (en) begin
      n.sat = 1'b0;
      if (up_down) begin
        if (m.q < modulo - 1) n.q = m.q + 1;
        else if (satm) n.sat = 1'b1;
        else begin
          n.q = 0;
          n.wrap = 1'b1;
        end
      end else begin
        if (m.q > 0) n.q = m.q - 1;
        else if (satm) n.sat = 1'b1;
        else begin
          n.q = modulo - 1;
          n.wrap = 1'b1;
        end
      end
    end
    return n;
  endfunction

  function automatic mdl_t zero_mdl();
    mdl_t z;
    z.q = 0;
    z.wrap = 1'b0;
    z.sat = 1'b0;
    z.lerr = 1'b0;
    return z;
  endfunction

  function automatic bit exp_tc(input int q, input int modulo);
    return up_down ? (q == modulo - 1) : (q == 0);
  endfunction

  task automatic check_all();
    check("w.q",    32'(q_w),    32'(m_w.q));
    check("w.tc",   32'(tc_w),   32'(exp_tc(m_w.q, 10)));
    check("w.wrap", 32'(wrap_w), 32'(m_w.wrap));
    check("w.sat",  32'(sat_w),  32'(m_w.sat));
    check("w.lerr", 32'(lerr_w), 32'(m_w.lerr));
    check("s.q",    32'(q_s),    32'(m_s.q));
    check("s.tc",   32'(tc_s),   32'(exp_tc(m_s.q, 10)));
    check("s.wrap", 32'(wrap_s), 32'(m_s.wrap));
    check("s.sat",  32'(sat_s),  32'(m_s.sat));
    check("s.lerr", 32'(lerr_s), 32'(m_s.lerr));
    check("f.q",    32'(q_f),    32'(m_f.q));
    check("f.tc",   32'(tc_f),   32'(exp_tc(m_f.q, 256)));
    check("f.wrap", 32'(wrap_f), 32'(m_f.wrap));
    check("f.sat",  32'(sat_f),  32'(m_f.sat));
    check("f.lerr", 32'(lerr_f), 32'(m_f.lerr));
  endtask

  // One clock edge: advance the models, then compare just after the edge.
  task automatic tick();
    @(posedge clk);
    if (!rst) begin
      m_w = zero_mdl();
      m_s = zero_mdl();
      m_f = zero_mdl();
    end else begin
      m_w = step(m_w, 10,  1'b0, int'(lv4));
      m_s = step(m_s, 10,  1'b1, int'(lv4));
      m_f = step(m_f, 256, 1'b0, int'(lv8));
    end
    #1;
    check_all();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic set_ctl(input bit c, input bit l, input bit e, input bit ud,
                         input int v4, input int v8);
    clr = c;
    load = l;
    en = e;
    up_down = ud;
    lv4 = 4'(v4);
    lv8 = 8'(v8);
  endtask

  // Asynchronous reset pulse between edges, checked before any clock arrives.
  task automatic async_reset();
    rst = 1'b0;
    #2;
    m_w = zero_mdl();
    m_s = zero_mdl();
    m_f = zero_mdl();
    check_all();
    tick();
    rst = 1'b1;
  endtask

  initial begin
    rst = 1'b0;
    set_ctl(1'b0, 1'b0, 1'b0, 1'b1, 0, 0);
    m_w = zero_mdl();
    m_s = zero_mdl();
    m_f = zero_mdl();
    #1;
    check_all();
    tick();
    rst = 1'b1;

    // Count to 7, reset mid-cycle, count to 5, then clear.
    set_ctl(1'b0, 1'b0, 1'b1, 1'b1, 0, 0);
    ticks(7);
    check("count7", 32'(q_w), 32'd7);
    async_reset();
    ticks(5);
    set_ctl(1'b1, 1'b0, 1'b1, 1'b1, 0, 0);
    tick();
    check("clr.q", 32'(q_w), 32'd0);

    // Up wrap through 9 -> 0, saturation instance sticks at 9.
    set_ctl(1'b0, 1'b0, 1'b1, 1'b1, 0, 0);
    ticks(11);

    // Down wrap from 2: 2, 1, 0, 9.
    set_ctl(1'b0, 1'b1, 1'b0, 1'b0, 2, 2);
    tick();
    set_ctl(1'b0, 1'b0, 1'b1, 1'b0, 0, 0);
    ticks(4);

    // Saturate at 9 from 8, then reverse direction.
    set_ctl(1'b0, 1'b1, 1'b0, 1'b1, 8, 8);
    tick();
    set_ctl(1'b0, 1'b0, 1'b1, 1'b1, 0, 0);
    ticks(3);
    check("sat.hold", 32'(sat_s), 32'd1);
    up_down = 1'b0;
    tick();
    check("sat.rev", 32'(q_s), 32'd8);

    // Loads: in range, out of range, clear over load, load over count.
    set_ctl(1'b0, 1'b1, 1'b0, 1'b1, 6, 6);
    tick();
    set_ctl(1'b0, 1'b1, 1'b0, 1'b1, 12, 12);
    tick();
    check("lerr", 32'(lerr_w), 32'd1);
    set_ctl(1'b0, 1'b0, 1'b0, 1'b1, 0, 0);
    tick();
    set_ctl(1'b1, 1'b1, 1'b1, 1'b1, 5, 5);
    tick();
    set_ctl(1'b0, 1'b1, 1'b1, 1'b1, 4, 200);
    tick();

    // Full-range rollover 255 -> 0, then hold with enable low.
    set_ctl(1'b0, 1'b1, 1'b0, 1'b1, 3, 250);
    tick();
    set_ctl(1'b0, 1'b0, 1'b1, 1'b1, 0, 0);
    ticks(8);
    en = 1'b0;
    ticks(3);

    // Randomised controls with occasional mid-cycle resets.
    for (int i = 0; i < 600; i++) begin
      clr     = ($urandom_range(0, 19) == 0);
      load    = ($urandom_range(0, 7) == 0);
      en      = ($urandom_range(0, 3) != 0);
      up_down = ($urandom_range(0, 2) != 0) ? up_down : ~up_down;
      lv4     = 4'($urandom_range(0, 15));
      lv8     = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 99) == 0) async_reset();
      else tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
